// File: rtl/image_pkg.sv
// Shared types and constants for the image pipeline.
// Covers state encodings, colour phases and the pixel word width.
package image_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_RED   = 2'd0,
    PH_GREEN = 2'd1,
    PH_BLUE  = 2'd2
  } phase_e;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int PIX_W           = 24;

  function automatic phase_e next_phase(
    input phase_e p
  );
    if (int'(p) == BYTES_PER_PIXEL - 1)
      return PH_RED;
    return phase_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/rgb_pixel_packer_if.sv
// Byte-in / pixel-out handshake bundle of rgb_pixel_packer.
// The slave view belongs to the packer and the master view to its environment.
interface rgb_pixel_packer_if #(
  parameter int ROW_W = 1,
  parameter int COL_W = 2
);
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [23:0]      pix_out;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;
  logic             pix_valid;
  logic             pix_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  start, byte_in, byte_valid,
    input  pix_ready,
    output byte_ready, pix_out, pix_row,
    output pix_col, pix_sof, pix_eol,
    output pix_eof, pix_valid, busy, done
  );

  modport master (
    output start, byte_in, byte_valid,
    output pix_ready,
    input  byte_ready, pix_out, pix_row,
    input  pix_col, pix_sof, pix_eol,
    input  pix_eof, pix_valid, busy, done
  );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with a registered head word.
// The head register always mirrors the entry at the read pointer.
module pixel_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push)
      wr_d = wr_q + AW'(1);
    if (do_pop)
      rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= din;
  end

  // A push landing on the new head bypasses the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && wr_q == rd_d)
        dout_q <= din;
      else if (do_pop)
        dout_q <= mem_q[rd_d];
    end
  end
endmodule

// File: rtl/rgb_pixel_packer.sv
// Packs an interleaved R,G,B byte stream into tagged 24-bit pixels.
// Pixels carry row/column and frame markers through an output FIFO.
module rgb_pixel_packer
  import image_pkg::*;
#(
  parameter int WIDTH      = 788,
  parameter int HEIGHT     = 1080,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = $clog2(HEIGHT),
  parameter int COL_W      = $clog2(WIDTH)
) (
  input logic clk,
  input logic reset,
  rgb_pixel_packer_if.slave bus
);
  localparam int ENT_W = 3 + ROW_W + COL_W + PIX_W;
  localparam logic [ROW_W-1:0] ROW_LAST =
    ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(WIDTH - 1);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;

  logic             full, empty;
  logic             accept, push;
  logic             sof, eol, eof;
  logic [ENT_W-1:0] ent_in, ent_out;

  assign bus.byte_ready = (state_q == ST_RUN) && !full;
  assign accept = bus.byte_valid && bus.byte_ready;
  assign push   = accept && (phase_q == PH_BLUE);

  assign sof = (row_q == '0) && (col_q == '0);
  assign eol = col_q == COL_LAST;
  assign eof = eol && (row_q == ROW_LAST);

  assign ent_in = {eof, eol, sof, row_q, col_q,
                   r_q, g_q, bus.byte_in};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    row_d   = row_q;
    col_d   = col_q;
    r_d     = r_q;
    g_d     = g_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          phase_d = PH_RED;
          row_d   = '0;
          col_d   = '0;
          r_d     = '0;
          g_d     = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          phase_d = next_phase(phase_q);
          unique case (1'b1)
            (phase_q == PH_RED):   r_d = bus.byte_in;
            (phase_q == PH_GREEN): g_d = bus.byte_in;
            default: begin
              if (eol) begin
                col_d = '0;
                row_d = eof ? '0 : row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
              if (eof)
                state_d = ST_DRAIN;
            end
          endcase
        end
      end
      ST_DRAIN: begin
        if (empty)
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_RED;
      row_q   <= '0;
      col_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      col_q   <= col_d;
      r_q     <= r_d;
      g_q     <= g_d;
    end
  end

  pixel_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ent_in),
    .pop   (bus.pix_ready),
    .dout  (ent_out),
    .full  (full),
    .empty (empty)
  );

  assign {bus.pix_eof, bus.pix_eol, bus.pix_sof,
          bus.pix_row, bus.pix_col,
          bus.pix_out} = ent_out;
  assign bus.pix_valid = !empty;
  assign bus.busy = (state_q == ST_RUN) ||
                    (state_q == ST_DRAIN);
  assign bus.done = state_q == ST_DONE;
endmodule

// File: tb/tb_rgb_pixel_packer.sv
// Directed bench for rgb_pixel_packer on a 4x2 frame.
// Popped pixels are collected and compared with hand-derived values.
module tb_rgb_pixel_packer;
  logic clk;
  logic reset;

  rgb_pixel_packer_if #(.ROW_W(1), .COL_W(2)) bus ();

  rgb_pixel_packer #(
    .WIDTH      (4),
    .HEIGHT     (2),
    .FIFO_DEPTH (4),
    .ROW_W      (1),
    .COL_W      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] pix;
    logic [0:0]  row;
    logic [1:0]  col;
    logic        sof;
    logic        eol;
    logic        eof;
  } px_t;

  px_t got[$];
  int  checks = 0;
  int  errors = 0;
  int  rdy_mode = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2)
        bus.pix_ready = 1'($urandom_range(0, 1));
      else
        bus.pix_ready = (rdy_mode == 1);
    end
  end

  always @(negedge clk) begin
    if (reset && bus.pix_valid && bus.pix_ready)
      got.push_back('{bus.pix_out, bus.pix_row,
                      bus.pix_col, bus.pix_sof,
                      bus.pix_eol, bus.pix_eof});
  end

  task automatic feed(input logic [7:0] base,
                      input int n, input int max_cyc,
                      input bit gaps,
                      output int acc, output int cyc);
    bit ph = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < max_cyc) begin
      bus.byte_in    = base + 8'(acc);
      bus.byte_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      @(negedge clk);
      if (bus.byte_valid && bus.byte_ready)
        acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", 32'(bus.done), 1);
  endtask

  task automatic chk_reset_vals(input string tg);
    chk({tg, "_brdy"}, 32'(bus.byte_ready), 0);
    chk({tg, "_pval"}, 32'(bus.pix_valid), 0);
    chk({tg, "_pix"},  32'(bus.pix_out), 0);
    chk({tg, "_row"},  32'(bus.pix_row), 0);
    chk({tg, "_col"},  32'(bus.pix_col), 0);
    chk({tg, "_flags"},
        32'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 0);
    chk({tg, "_busy"}, 32'(bus.busy), 0);
    chk({tg, "_done"}, 32'(bus.done), 0);
  endtask

  task automatic check_frame(input logic [7:0] base,
                             input string tg);
    logic [7:0]  b;
    logic [23:0] ep;
    chk({tg, "_npix"}, 32'(got.size()), 8);
    for (int k = 0; k < got.size() && k < 8; k++) begin
      b  = base + 8'(3 * k);
      ep = {b, b + 8'd1, b + 8'd2};
      chk($sformatf("%s_pix%0d", tg, k),
          32'(got[k].pix), 32'(ep));
      chk($sformatf("%s_rc%0d", tg, k),
          32'({got[k].row, got[k].col}), 32'(k));
      chk($sformatf("%s_fl%0d", tg, k),
          32'({got[k].sof, got[k].eol, got[k].eof}),
          32'({k == 0, (k % 4) == 3, k == 7}));
    end
  endtask

  int acc, cyc;

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // basic frame
    chk("idle_busy", 32'(bus.busy), 0);
    do_start();
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_brdy", 32'(bus.byte_ready), 1);
    got.delete();
    feed(8'h01, 24, 100, 1'b0, acc, cyc);
    chk("basic_acc", 32'(acc), 24);
    chk("basic_cyc", 32'(cyc), 24);
    chk("drain_brdy", 32'(bus.byte_ready), 0);
    wait_done();
    check_frame(8'h01, "basic");
    if (got.size() == 8) begin
      chk("first_pix", 32'(got[0].pix), 32'h010203);
      chk("first_sof", 32'(got[0].sof), 1);
      chk("p3_pix", 32'(got[3].pix), 32'h0A0B0C);
      chk("p3_eol", 32'(got[3].eol), 1);
      chk("last_pix", 32'(got[7].pix), 32'h161718);
      chk("last_rc", 32'({got[7].row, got[7].col}), 7);
      chk("last_eof", 32'(got[7].eof), 1);
    end

    // restart from DONE with one excess byte
    do_start();
    got.delete();
    feed(8'h31, 25, 40, 1'b0, acc, cyc);
    chk("excess_acc", 32'(acc), 24);
    chk("excess_brdy", 32'(bus.byte_ready), 0);
    wait_done();
    chk("done_brdy", 32'(bus.byte_ready), 0);
    check_frame(8'h31, "restart");

    // backpressure
    rdy_mode = 0;
    bus.pix_ready = 1'b0;
    do_start();
    got.delete();
    feed(8'h01, 24, 40, 1'b0, acc, cyc);
    chk("bp_acc", 32'(acc), 12);
    chk("bp_brdy", 32'(bus.byte_ready), 0);
    chk("bp_pval", 32'(bus.pix_valid), 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_head", 32'(bus.pix_out), 32'h010203);
      @(posedge clk);
      #1;
    end
    chk("bp_npop", 32'(got.size()), 0);
    rdy_mode = 1;
    bus.pix_ready = 1'b1;
    feed(8'h0D, 12, 100, 1'b0, acc, cyc);
    chk("bp_acc2", 32'(acc), 12);
    wait_done();
    check_frame(8'h01, "bp");

    // input gaps with random pixel stalls
    rdy_mode = 2;
    do_start();
    got.delete();
    feed(8'h01, 24, 400, 1'b1, acc, cyc);
    chk("gap_acc", 32'(acc), 24);
    rdy_mode = 1;
    bus.pix_ready = 1'b1;
    wait_done();
    check_frame(8'h01, "gaps");

    // reset mid-frame
    do_start();
    feed(8'hA0, 7, 20, 1'b0, acc, cyc);
    chk("mid_acc", 32'(acc), 7);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    do_start();
    feed(8'h51, 24, 100, 1'b0, acc, cyc);
    wait_done();
    check_frame(8'h51, "after_rst");
    if (got.size() > 0)
      chk("after_rst_p0", 32'(got[0].pix), 32'h515253);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_pixel_packer.md
# rgb_pixel_packer

Upstream stage of the image-processing pipeline. It accepts the raw interleaved byte stream (R, G, B per pixel, raster order) under a valid/ready handshake and assembles 24-bit pixels. Each pixel leaves through a small output FIFO, tagged with its row/column coordinates and frame markers. The kernel-filter stage consumes it, so that stage no longer counts colour cycles itself.

## Interface
- `WIDTH`, default 788, pixels per row.
- `HEIGHT`, default 1080, rows per frame.
- `FIFO_DEPTH`, default 4, output pixel FIFO entries (power of two, ≥2).
- `ROW_W`, default `$clog2(HEIGHT)`, row coordinate width.
- `COL_W`, default `$clog2(WIDTH)`, column coordinate width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `start`  in  1  begin a frame; sampled only in IDLE or DONE.
- `byte_in`  in  8  input colour byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  byte accepted when `byte_valid && byte_ready`.
- `pix_out`  out  24  `{R,G,B}`, R in [23:16].
- `pix_row`  out  ROW_W  row of `pix_out`.
- `pix_col`  out  COL_W  column of `pix_out`.
- `pix_sof`  out  1  pixel is (0,0).
- `pix_eol`  out  1  pixel is column WIDTH-1.
- `pix_eof`  out  1  pixel is (HEIGHT-1, WIDTH-1).
- `pix_valid`  out  1  FIFO head valid.
- `pix_ready`  in  1  downstream pops head when `pix_valid && pix_ready`.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.

## Operation
- **State machine:** IDLE → RUN on `start`. RUN → DRAIN on acceptance of the frame's last blue byte. DRAIN → DONE when the FIFO is empty. DONE → RUN on `start`.
  - `start` is ignored in RUN and DRAIN.
- **Entry to RUN:** clears the phase counter (0..2), row, column and the R/G holding registers.
- **`byte_ready`:** equals `(state==RUN) && !fifo_full`. It is combinational from registered state only; it never depends on `byte_valid`.
- **Byte acceptance:**
  - Phase 0 stores R; phase 1 stores G.
  - Phase 2 pushes `{R,G,byte_in}` plus coordinates and flags into the FIFO, then advances the column.
  - The column wraps at WIDTH-1 to 0 and increments the row.
- **Stall:** the phase counter advances only on accepted bytes. Gaps in `byte_valid` and stalls never lose or reorder bytes.
- **FIFO full:** an R/G byte is also refused when full. Accepted bytes are never dropped.
- **Flags:** computed from the counters at push time and stored in the FIFO entry.
- **Simultaneous push and pop:** occupancy unchanged. Pop when empty is impossible (`pix_valid`=0).
- **After the last pixel:** in DRAIN and DONE, `byte_ready`=0. Extra input bytes are not consumed.
- **Reset mid-frame:** counters and FIFO are cleared, any partial pixel is discarded, and state returns to IDLE.

## Timing
- **Reset values:** `byte_ready`=0, `pix_valid`=0, `pix_out`=0, `pix_row`=0, `pix_col`=0, all flags 0, `busy`=0, `done`=0, state IDLE.
- **`start`:** `busy` rises the cycle after `start` is sampled. `byte_ready` rises in the same cycle if the FIFO is not full.
- **Latency:** a pixel is visible at the FIFO head (`pix_valid`=1) one cycle after its blue byte is accepted, provided the FIFO was empty.
- **Throughput:** one byte per cycle, one pixel per three cycles when unstalled. A full frame takes 3·WIDTH·HEIGHT accepted bytes.
- **Head stability:** FIFO outputs are registered. The head entry is stable while `pix_valid && !pix_ready`.
- **DONE:** `done` asserts the cycle after the FIFO empties in DRAIN. It holds until `start` or reset.

## Structure
- **Shared package `image_pkg`:**
  - state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - `BYTES_PER_PIXEL`=3;
  - colour phase constants (RED=0, GREEN=1, BLUE=2);
  - pixel word width 24.
- **Sub-module `pixel_fifo`:**
  - synchronous FIFO with parameters `DATA_W` and `DEPTH`;
  - `full`/`empty` outputs, registered read data;
  - the same asynchronous active-low reset.
- **Entry packing:** `{eof, eol, sof, row, col, rgb}` as one data word.

## Test plan
Bench uses WIDTH=4, HEIGHT=2, FIFO_DEPTH=4 unless stated.
- **Basic frame:** reset, `start`, 24 bytes 0x01..0x18 with `byte_valid`=1 and `pix_ready`=1 → 8 pixels.
  - First pixel 0x010203 at (0,0) with `pix_sof`=1; pixel 3 = 0x0A0B0C with `pix_eol`=1.
  - Last pixel 0x161718 at (1,3) with `pix_eof`=1; `done`=1 afterwards.
- **Backpressure:** `pix_ready`=0 throughout with bytes offered.
  - Exactly 12 bytes are accepted (4 pixels), then `byte_ready`=0 and the head holds 0x010203.
  - Releasing `pix_ready` → the remaining 4 pixels arrive in order and none is lost.
- **Input gaps:** `byte_valid` toggles every other cycle, random pixel stalls → output sequence identical to the basic frame.
- **Reset mid-frame:** assert reset after 7 bytes → all outputs at reset values. A new `start` plus 24 bytes → first pixel taken from the new bytes 0..2, coordinates (0,0).
- **Restart and excess input:** `start` in DONE begins a second frame with counters at (0,0). A 25th byte offered after the last pixel is never accepted (`byte_ready`=0 in DRAIN/DONE).
